// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multiply/divide sequencer.
// Imported by the sequencer top and its watchdog counter.
package muldiv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT,
        WRITE,
        ZERO
    } state_t;

    localparam logic [1:0] OPK_MULT = 2'b00;
    localparam logic [1:0] OPK_DIV  = 2'b01;

    localparam int TIMEOUT_CYCLES_DEF = 64;

    // op_kind values with the upper bit set are not MULT/DIV
    function automatic logic opk_illegal(input logic [1:0] kind);
        return kind[1];
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request handshake between the control unit and the sequencer.
// master = control unit, slave = muldiv_sequencer.
interface muldiv_if #(
    parameter int WIDTH = 32
);

    logic             op_valid;
    logic             op_ready;
    logic [1:0]       op_kind;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;

    modport master (
        output op_valid,
        output op_kind,
        output a_in,
        output b_in,
        input  op_ready
    );

    modport slave (
        input  op_valid,
        input  op_kind,
        input  a_in,
        input  b_in,
        output op_ready
    );

endinterface

// File: rtl/muldiv_watchdog.sv
// WAIT-cycle counter: clear/enable/saturate, last-count capture.
// With MULDIV_WATCHDOG_EN defined it also flags the timeout limit.
module muldiv_watchdog #(
    parameter int CNT_W          = 7,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic             cap,
`ifdef MULDIV_WATCHDOG_EN
    output logic             at_limit,
`endif
    output logic [CNT_W-1:0] last_cycles
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    if (TIMEOUT_CYCLES >= (1 << CNT_W)) begin : g_width_chk
        $error("CNT_W too narrow for TIMEOUT_CYCLES");
    end

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;

    // count value including the current cycle, held at max
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

`ifdef MULDIV_WATCHDOG_EN
    assign at_limit = en && (cnt_inc == CNT_W'(TIMEOUT_CYCLES));
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt         <= '0;
            last_cycles <= '0;
        end else begin
            if (clr) begin
                cnt <= '0;
            end else if (en) begin
                cnt <= cnt_inc;
            end
            if (cap) begin
                last_cycles <= cnt_inc;
            end
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Sequences shared MULT/DIV units and commits results to HI/LO.
// Build option: MULDIV_WATCHDOG_EN enables the WAIT timeout abort.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int CNT_W          = 7
) (
    input  logic             clk,
    input  logic             reset,
    muldiv_if.slave          req,
    input  logic             flush,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic             mult_start,
    output logic             div_start,
    input  logic             mult_ready,
    input  logic             div_ready,
    input  logic [WIDTH-1:0] mult_hi,
    input  logic [WIDTH-1:0] mult_lo,
    input  logic [WIDTH-1:0] div_hi,
    input  logic [WIDTH-1:0] div_lo,
    output logic             hi_wr,
    output logic             lo_wr,
    output logic [WIDTH-1:0] hi_data,
    output logic [WIDTH-1:0] lo_data,
    output logic             busy,
    output logic             done,
    output logic             div_zero_exc,
    output logic             illegal,
    output logic             timeout,
    output logic [CNT_W-1:0] last_cycles
);

    state_t state;
    state_t state_nxt;

    logic is_div_q;
    logic illegal_q;
    logic req_seen;
    logic req_bad;
    logic req_div;
    logic accept;
    logic sel_ready;
    logic cap;
    logic cnt_clr;
    logic cnt_en;
    logic timeout_c;
`ifdef MULDIV_WATCHDOG_EN
    logic at_limit;
`endif

    // a request is only seen in IDLE and never under flush
    assign req_seen = (state == IDLE) && req.op_valid && !flush;
    assign req_bad  = opk_illegal(req.op_kind);
    assign req_div  = (req.op_kind == OPK_DIV);
    assign accept   = req_seen && !req_bad;

    assign sel_ready = is_div_q ? div_ready : mult_ready;

    assign req.op_ready = (state == IDLE);
    assign busy         = (state != IDLE);
    assign illegal      = illegal_q;
    assign timeout      = timeout_c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        mult_start   = 1'b0;
        div_start    = 1'b0;
        hi_wr        = 1'b0;
        lo_wr        = 1'b0;
        done         = 1'b0;
        div_zero_exc = 1'b0;
        cap          = 1'b0;
        cnt_clr      = 1'b0;
        cnt_en       = 1'b0;
        timeout_c    = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (req_div && (req.b_in == '0)) begin
                        state_nxt = ZERO;
                    end else begin
                        state_nxt = START;
                    end
                end
            end
            START: begin
                mult_start = !is_div_q;
                div_start  = is_div_q;
                cnt_clr    = 1'b1;
                state_nxt  = flush ? IDLE : WAIT;
            end
            WAIT: begin
                cnt_en = 1'b1;
                if (flush) begin
                    state_nxt = IDLE;
                end else if (sel_ready) begin
                    cap       = 1'b1;
                    state_nxt = WRITE;
`ifdef MULDIV_WATCHDOG_EN
                end else if (at_limit) begin
                    timeout_c = 1'b1;
                    state_nxt = IDLE;
`endif
                end
            end
            WRITE: begin
                hi_wr     = !flush;
                lo_wr     = !flush;
                done      = !flush;
                state_nxt = IDLE;
            end
            ZERO: begin
                div_zero_exc = !flush;
                state_nxt    = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_a      <= '0;
            op_b      <= '0;
            hi_data   <= '0;
            lo_data   <= '0;
            is_div_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            if (accept) begin
                op_a     <= req.a_in;
                op_b     <= req.b_in;
                is_div_q <= req_div;
            end
            if (cap) begin
                hi_data <= is_div_q ? div_hi : mult_hi;
                lo_data <= is_div_q ? div_lo : mult_lo;
            end
            illegal_q <= req_seen && req_bad;
        end
    end

    muldiv_watchdog #(
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk         (clk),
        .reset       (reset),
        .clr         (cnt_clr),
        .en          (cnt_en),
        .cap         (cap),
`ifdef MULDIV_WATCHDOG_EN
        .at_limit    (at_limit),
`endif
        .last_cycles (last_cycles)
    );

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench: stimulus queues expected strobes, monitor compares.
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    localparam int W  = 32;
    localparam int CW = 7;

    localparam int EV_MS  = 0;
    localparam int EV_DS  = 1;
    localparam int EV_WR  = 2;
    localparam int EV_DZ  = 3;
    localparam int EV_ILL = 4;
    localparam int EV_TO  = 5;

    typedef struct {
        int          kind;
        int          at;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lc;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          mult_ready, div_ready;
    logic [W-1:0]  mult_hi, mult_lo, div_hi, div_lo;
    logic [W-1:0]  op_a, op_b, hi_data, lo_data;
    logic          mult_start, div_start, hi_wr, lo_wr;
    logic          busy, done, div_zero_exc, illegal, timeout;
    logic [CW-1:0] last_cycles;

    int   cyc    = 0;
    int   errs   = 0;
    int   checks = 0;
    exp_t sbq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    muldiv_if #(.WIDTH(W)) req();

    muldiv_sequencer #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .flush        (flush),
        .op_a         (op_a),
        .op_b         (op_b),
        .mult_start   (mult_start),
        .div_start    (div_start),
        .mult_ready   (mult_ready),
        .div_ready    (div_ready),
        .mult_hi      (mult_hi),
        .mult_lo      (mult_lo),
        .div_hi       (div_hi),
        .div_lo       (div_lo),
        .hi_wr        (hi_wr),
        .lo_wr        (lo_wr),
        .hi_data      (hi_data),
        .lo_data      (lo_data),
        .busy         (busy),
        .done         (done),
        .div_zero_exc (div_zero_exc),
        .illegal      (illegal),
        .timeout      (timeout),
        .last_cycles  (last_cycles)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic expect_ev(input int k, input int at,
                             input logic [31:0] h = 0,
                             input logic [31:0] l = 0,
                             input int lc = 0);
        exp_t e;
        e = '{kind: k, at: at, hi: h, lo: l, lc: lc};
        sbq.push_back(e);
    endtask

    task automatic seen(input int k);
        exp_t e;
        checks++;
        if (sbq.size() == 0) begin
            errs++;
            $display("FAIL unexpected event: got kind %0d at cycle %0d, want none",
                     k, cyc);
            return;
        end
        e = sbq.pop_front();
        if (e.kind != k || e.at != cyc) begin
            errs++;
            $display("FAIL event order: got kind %0d at %0d, want kind %0d at %0d",
                     k, cyc, e.kind, e.at);
        end
        if (k == EV_WR) begin
            checks++;
            if ({hi_wr, lo_wr, done} !== 3'b111 || hi_data !== e.hi ||
                lo_data !== e.lo || last_cycles !== CW'(e.lc)) begin
                errs++;
                $display("FAIL write data: got wr=%b hi=%0d lo=%0d lc=%0d, want 111 hi=%0d lo=%0d lc=%0d",
                         {hi_wr, lo_wr, done}, hi_data, lo_data, last_cycles,
                         e.hi, e.lo, e.lc);
            end
        end
    endtask

    always @(negedge clk) begin
        if (mult_start === 1'b1) seen(EV_MS);
        if (div_start === 1'b1) seen(EV_DS);
        if ((hi_wr | lo_wr | done) === 1'b1) seen(EV_WR);
        if (div_zero_exc === 1'b1) seen(EV_DZ);
        if (illegal === 1'b1) seen(EV_ILL);
        if (timeout === 1'b1) seen(EV_TO);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] k, input logic [31:0] a,
                         input logic [31:0] b, output int t0);
        req.op_valid = 1'b1;
        req.op_kind  = k;
        req.a_in     = a;
        req.b_in     = b;
        t0 = cyc;
        step();
        req.op_valid = 1'b0;
        req.op_kind  = 2'b00;
        req.a_in     = '0;
        req.b_in     = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL global timeout: got no finish, want finish");
        $fatal(1);
    end

    initial begin
        int t0;
        reset        = 1'b1;
        flush        = 1'b0;
        mult_ready   = 1'b0;
        div_ready    = 1'b0;
        mult_hi      = '0;
        mult_lo      = '0;
        div_hi       = '0;
        div_lo       = '0;
        req.op_valid = 1'b0;
        req.op_kind  = 2'b00;
        req.a_in     = '0;
        req.b_in     = '0;
        step();
        step();
        chk("rst op_ready", 64'(req.op_ready), 64'd1);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst op_a", 64'(op_a), 64'd0);
        chk("rst hi_data", 64'(hi_data), 64'd0);
        chk("rst last_cycles", 64'(last_cycles), 64'd0);
        reset = 1'b0;
        step();

        // MULT 7*6, ready 3 cycles after start
        issue(OPK_MULT, 32'd7, 32'd6, t0);
        expect_ev(EV_MS, t0 + 1);
        expect_ev(EV_WR, t0 + 5, 32'd0, 32'd42, 3);
        chk("mul op_a", 64'(op_a), 64'd7);
        chk("mul op_b", 64'(op_b), 64'd6);
        chk("mul op_ready busy", 64'(req.op_ready), 64'd0);
        repeat (3) step();
        mult_ready = 1'b1;
        mult_hi    = 32'd0;
        mult_lo    = 32'd42;
        step();
        mult_ready = 1'b0;
        step();
        chk("mul op_ready after", 64'(req.op_ready), 64'd1);
        chk("mul last_cycles", 64'(last_cycles), 64'd3);

        // DIV by zero
        issue(OPK_DIV, 32'd100, 32'd0, t0);
        expect_ev(EV_DZ, t0 + 1);
        step();
        chk("dz op_ready", 64'(req.op_ready), 64'd1);

        // DIV 100/7 with stray mult_ready pulses
        issue(OPK_DIV, 32'd100, 32'd7, t0);
        expect_ev(EV_DS, t0 + 1);
        expect_ev(EV_WR, t0 + 7, 32'd2, 32'd14, 5);
        mult_hi = 32'd99;
        mult_lo = 32'd99;
        for (int i = 0; i < 2; i++) begin
            step();
            mult_ready = 1'b1;
            step();
            mult_ready = 1'b0;
        end
        step();
        div_ready = 1'b1;
        div_hi    = 32'd2;
        div_lo    = 32'd14;
        step();
        div_ready = 1'b0;
        step();
        chk("div last_cycles", 64'(last_cycles), 64'd5);

        // flush in second WAIT cycle, late ready ignored
        issue(OPK_MULT, 32'd3, 32'd5, t0);
        expect_ev(EV_MS, t0 + 1);
        step();
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush idle", 64'(req.op_ready), 64'd1);
        chk("flush busy", 64'(busy), 64'd0);
        step();
        mult_ready = 1'b1;
        mult_lo    = 32'd15;
        step();
        mult_ready = 1'b0;
        step();
        chk("flush last_cycles", 64'(last_cycles), 64'd5);

        // flush coinciding with WRITE
        issue(OPK_MULT, 32'd2, 32'd2, t0);
        expect_ev(EV_MS, t0 + 1);
        step();
        mult_ready = 1'b1;
        mult_lo    = 32'd4;
        step();
        mult_ready = 1'b0;
        flush      = 1'b1;
        #1;
        chk("wr flush hi_wr", 64'(hi_wr), 64'd0);
        chk("wr flush done", 64'(done), 64'd0);
        step();
        flush = 1'b0;
        chk("wr flush op_ready", 64'(req.op_ready), 64'd1);

        // illegal op_kind
        issue(2'b10, 32'd1, 32'd1, t0);
        expect_ev(EV_ILL, t0 + 1);
        chk("ill busy", 64'(busy), 64'd0);
        step();
        chk("ill op_ready", 64'(req.op_ready), 64'd1);

        // reset during WAIT
        issue(OPK_MULT, 32'd9, 32'd9, t0);
        expect_ev(EV_MS, t0 + 1);
        step();
        reset = 1'b1;
        #1;
        chk("rstw busy", 64'(busy), 64'd0);
        chk("rstw op_a", 64'(op_a), 64'd0);
        chk("rstw hi_data", 64'(hi_data), 64'd0);
        chk("rstw last_cycles", 64'(last_cycles), 64'd0);
        step();
        reset = 1'b0;
        step();
        chk("rstw op_ready", 64'(req.op_ready), 64'd1);

        // unit never answers
        issue(OPK_MULT, 32'd1, 32'd1, t0);
        expect_ev(EV_MS, t0 + 1);
`ifdef MULDIV_WATCHDOG_EN
        expect_ev(EV_TO, t0 + 1 + TIMEOUT_CYCLES_DEF);
        repeat (TIMEOUT_CYCLES_DEF + 4) step();
        chk("wd op_ready", 64'(req.op_ready), 64'd1);
`else
        repeat (205) step();
        chk("hang busy", 64'(busy), 64'd1);
        chk("hang timeout", 64'(timeout), 64'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("hang op_ready", 64'(req.op_ready), 64'd1);
`endif

        repeat (3) step();
        checks++;
        if (sbq.size() != 0) begin
            errs++;
            $display("FAIL pending events: got %0d left, want 0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
